// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word requests to instruction memory and
// buffers returned words with their PCs for decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = AW + 3;
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];

    logic          pop;
    logic          gnt;
    logic          drop;
    logic          push;
    logic [SW-1:0] credit;
    logic [31:0]   target;
    logic [CW-1:0] gnt_c;
    logic [CW-1:0] push_c;
    logic [CW-1:0] pop_c;
    logic [CW-1:0] drop_c;
    logic [CW-1:0] rvalid_c;

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr] : NOP;
    assign pc_o          = instr_valid_o ? fifo_pc[rd_ptr] : 32'h0;
    assign imem_addr_o   = fetch_pc;
    assign target        = {redirect_pc_i[31:2], 2'b00};

    assign pop  = instr_valid_o && instr_ready_i;
    assign gnt  = imem_req_o && imem_gnt_i;
    assign drop = imem_rvalid_i && (discard != '0);
    assign push = imem_rvalid_i && (discard == '0) && !redirect_i;

    assign gnt_c    = {{(CW-1){1'b0}}, gnt};
    assign push_c   = {{(CW-1){1'b0}}, push};
    assign pop_c    = {{(CW-1){1'b0}}, pop};
    assign drop_c   = {{(CW-1){1'b0}}, drop};
    assign rvalid_c = {{(CW-1){1'b0}}, imem_rvalid_i};

    // Every in-flight or buffered word holds a credit, so a kept response
    // always lands in a free entry.
    always_comb begin
        credit = {2'b00, outstanding} + {2'b00, discard} + {2'b00, count}
               - {{(SW-1){1'b0}}, pop};
        imem_req_o = !rst && !redirect_i && (credit < DEPTH_S);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= target;
            resp_pc     <= target;
            // A response in this cycle belongs to the old path either way.
            discard     <= discard + outstanding - rvalid_c;
            outstanding <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (gnt) fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            outstanding <= outstanding + gnt_c - push_c;
            discard     <= discard - drop_c;
            count       <= count + push_c - pop_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_instr[wr_ptr] <= imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomised bench for instr_fetch with an in-order,
// variable-latency instruction memory model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_ready;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .instr_valid_o(instr_valid),
        .instr_o      (instr),
        .pc_o         (pc),
        .instr_ready_i(instr_ready)
    );

    always #5 clk = ~clk;

    // memory model state
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          mq_ep[$];
    int          cyc;
    int          last_due;
    int          lat;
    bit          lat_rand;
    int          epoch;
    int          grants;

    // values sampled in the last cycle
    logic        s_req, s_valid, r_valid;
    logic [31:0] s_addr, s_instr, s_pc;
    int          r_ep;

    task automatic tick();
        int d;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq_addr[0];
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_instr = instr;
        s_pc    = pc;
        r_valid = 1'b0;
        if (imem_rvalid) begin
            r_valid = 1'b1;
            r_ep    = mq_ep[0];
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            void'(mq_ep.pop_front());
        end
        if (s_req && imem_gnt) begin
            d = cyc + (lat_rand ? $urandom_range(1, 4) : lat);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq_addr.push_back(s_addr);
            mq_due.push_back(d);
            mq_ep.push_back(epoch);
            grants++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        instr_ready = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        mq_ep.delete();
        tick();
        tick();
        rst      = 1'b0;
        cyc      = 0;
        last_due = -1;
        epoch    = 0;
        grants   = 0;
        mq_addr.delete();
        mq_due.delete();
        mq_ep.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req: got %b want 0", s_req);
        end
        n_checks++;
        if (s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", s_valid);
        end
        n_checks++;
        if (s_instr !== 32'h0000_0013) begin
            n_fail++;
            $display("FAIL reset_instr: got %h want 00000013", s_instr);
        end
        n_checks++;
        if (s_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc: got %h want 0", s_pc);
        end
        n_checks++;
        if (s_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 0", s_addr);
        end
    endtask

    task automatic test_linear();
        apply_reset();
        lat = 1;
        imem_gnt = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (s_req !== 1'b1 || s_addr !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL linear_req c%0d: got req=%b addr=%h want 1 %h",
                         i, s_req, s_addr, 32'(4 * i));
            end
            if (i >= 2) begin
                n_checks++;
                if (s_valid !== 1'b1 || s_pc !== 32'(4 * (i - 2))
                    || s_instr !== 32'(4 * (i - 2))) begin
                    n_fail++;
                    $display("FAIL linear_out c%0d: got v=%b pc=%h ins=%h want pc=ins=%h",
                             i, s_valid, s_pc, s_instr, 32'(4 * (i - 2)));
                end
            end else begin
                n_checks++;
                if (s_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL linear_early c%0d: got valid %b want 0", i, s_valid);
                end
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        lat = 1;
        imem_gnt = 1'b1;
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (grants != 4) begin
            n_fail++;
            $display("FAIL stall_grants: got %0d want 4", grants);
        end
        n_checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_full: got req=%b valid=%b want 0 1", s_req, s_valid);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (s_valid !== 1'b1 || s_pc !== 32'(4 * i) || s_instr !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stall_drain %0d: got v=%b pc=%h ins=%h want %h",
                         i, s_valid, s_pc, s_instr, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        bit seen;
        apply_reset();
        lat = 3;
        instr_ready = 1'b1;
        imem_gnt = 1'b1;
        tick();
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        n_checks++;
        if (s_req !== 1'b0 || mq_addr.size() != 2) begin
            n_fail++;
            $display("FAIL redir_out_setup: got req=%b inflight=%0d want 0 2",
                     s_req, mq_addr.size());
        end
        redirect = 1'b0;
        imem_gnt = 1'b1;
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_out_addr: got req=%b addr=%h want 1 00000100",
                     s_req, s_addr);
        end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (s_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || s_pc !== 32'h100 || s_instr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_out_head: got seen=%b pc=%h ins=%h want pc=ins=00000100",
                     seen, s_pc, s_instr);
        end
    endtask

    task automatic test_redirect_coincident();
        bit seen;
        apply_reset();
        lat = 1;
        imem_gnt = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        instr_ready = 1'b1;
        imem_gnt = 1'b0;
        tick();
        n_checks++;
        if (r_valid !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL coinc_pop: got rv=%b req=%b v=%b pc=%h want 1 0 1 0",
                     r_valid, s_req, s_valid, s_pc);
        end
        redirect = 1'b0;
        tick();
        n_checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL coinc_empty: got v=%b req=%b addr=%h want 0 1 00000200",
                     s_valid, s_req, s_addr);
        end
        imem_gnt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (s_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || s_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL coinc_next: got seen=%b pc=%h want 00000200", seen, s_pc);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        lat = 1;
        instr_ready = 1'b1;
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first: got req=%b addr=%h want 1 fffffffc", s_req, s_addr);
        end
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_second: got req=%b addr=%h want 1 00000000", s_req, s_addr);
        end
        tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_head: got v=%b pc=%h want 1 fffffffc", s_valid, s_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        int          buf_n;
        int          pops;
        apply_reset();
        lat_rand = 1'b1;
        exp_pc = 32'h0;
        buf_n = 0;
        pops = 0;
        for (int i = 0; i < 10000; i++) begin
            imem_gnt    = ($urandom_range(0, 99) < 70);
            instr_ready = ($urandom_range(0, 99) < 60);
            redirect    = ($urandom_range(0, 99) < 3);
            tgt         = $urandom;
            redirect_pc = tgt;
            tick();
            n_checks++;
            if (s_valid !== (buf_n > 0)) begin
                n_fail++;
                $display("FAIL rnd_valid c%0d: got %b want %b", i, s_valid, buf_n > 0);
            end
            if (redirect) begin
                n_checks++;
                if (s_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_redir_req c%0d: got %b want 0", i, s_req);
                end
            end
            if (s_valid && instr_ready) begin
                n_checks++;
                if (s_pc !== exp_pc || s_instr !== exp_pc) begin
                    n_fail++;
                    $display("FAIL rnd_pop c%0d: got pc=%h ins=%h want %h",
                             i, s_pc, s_instr, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                buf_n--;
                pops++;
            end
            if (redirect) begin
                buf_n = 0;
                epoch++;
                exp_pc = {tgt[31:2], 2'b00};
            end else if (r_valid && r_ep == epoch) begin
                buf_n++;
                n_checks++;
                if (buf_n > 4) begin
                    n_fail++;
                    $display("FAIL rnd_overflow c%0d: got %0d entries want <= 4", i, buf_n);
                end
            end
        end
        redirect = 1'b0;
        lat_rand = 1'b0;
        n_checks++;
        if (pops < 1000) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d pops want >= 1000", pops);
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        instr_ready = 1'b0;
        lat = 1;
        lat_rand = 1'b0;
        cyc = 0;
        last_due = -1;
        epoch = 0;
        grants = 0;
        @(negedge clk);
        test_reset();
        test_linear();
        test_stall();
        test_redirect_outstanding();
        test_redirect_coincident();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
